kbd_bram_ctrl: RTL and testbench

Scan-code sequencer between the PS/2 receiver and the on-chip block RAM. It decodes the PS/2 set-2 prefix bytes (E0 extended, F0 break) and writes each completed make code, tagged with its extended flag, into the next BRAM address. It shares the single-port BRAM between this keyboard write stream and a host read port, and supports a clear sweep of the whole memory.

---
 rtl/kbd_bram_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_kbd_bram_ctrl.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kbd_bram_ctrl.sv
// PS/2 set-2 scan-code sequencer: decodes E0/F0 prefixes and stores make codes
// into a single-port BRAM shared with a host read port and a clear sweep.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | waiting; arbitrates clr > pending write > host read
// S_WRITE   | ram_we high for one cycle with {ext, code} at address count
// S_READ    | ram_en high with ram_we low at rd_addr
// S_READ_WAIT| ram_rdata valid; rd_data captured and rd_valid pulses
// S_CLEAR   | writes 9'h000 to every address, one per cycle

module kbd_bram_ctrl #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              code_valid,
    input  logic [7:0]        key_code,
    input  logic              clr,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [8:0]        ram_wdata,
    input  logic [8:0]        ram_rdata,
    output logic [8:0]        rd_data,
    output logic              rd_valid,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              busy,
    output logic              overflow
);

    localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W+1)'(1 << ADDR_W);
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_READ_WAIT,
        S_CLEAR
    } state_t;

    state_t            state, state_nx;
    logic              ram_en_nx, ram_we_nx;
    logic [ADDR_W-1:0] ram_addr_nx;
    logic [8:0]        ram_wdata_nx;

    logic              ext_flag, brk_flag;
    logic              pend_valid;
    logic [8:0]        pending;
    logic              clr_pend;
    logic [8:0]        rd_data_q;

    logic is_prefix, keep_byte, pend_load, clr_req, clr_start;

    assign full      = (count == DEPTH_CNT);
    assign busy      = (state != S_IDLE);
    assign rd_valid  = (state == S_READ_WAIT);
    // ram_rdata is only valid during READ_WAIT, so present it directly then
    assign rd_data   = (state == S_READ_WAIT) ? ram_rdata : rd_data_q;

    assign is_prefix = (key_code == 8'hE0) || (key_code == 8'hF0);
    assign keep_byte = code_valid && !is_prefix && !brk_flag;
    assign pend_load = keep_byte && !pend_valid && !full;
    assign clr_req   = clr || clr_pend;
    assign clr_start = (state == S_IDLE) && clr_req;

    always_comb begin
        state_nx     = state;
        ram_en_nx    = 1'b0;
        ram_we_nx    = 1'b0;
        ram_addr_nx  = ram_addr;
        ram_wdata_nx = ram_wdata;
        case (state)
            S_IDLE: begin
                if (clr_req) begin
                    state_nx     = S_CLEAR;
                    ram_en_nx    = 1'b1;
                    ram_we_nx    = 1'b1;
                    ram_addr_nx  = '0;
                    ram_wdata_nx = 9'h000;
                end else if (pend_valid || pend_load) begin
                    // a byte arriving this cycle is written directly, giving a one-cycle write latency
                    state_nx     = S_WRITE;
                    ram_en_nx    = 1'b1;
                    ram_we_nx    = 1'b1;
                    ram_addr_nx  = count[ADDR_W-1:0];
                    ram_wdata_nx = pend_valid ? pending : {ext_flag, key_code};
                end else if (rd_req) begin
                    state_nx    = S_READ;
                    ram_en_nx   = 1'b1;
                    ram_addr_nx = rd_addr;
                end
            end
            S_WRITE:     state_nx = S_IDLE;
            S_READ:      state_nx = S_READ_WAIT;
            S_READ_WAIT: state_nx = S_IDLE;
            S_CLEAR: begin
                if (ram_addr == LAST_ADDR) begin
                    state_nx = S_IDLE;
                end else begin
                    ram_en_nx    = 1'b1;
                    ram_we_nx    = 1'b1;
                    ram_addr_nx  = ram_addr + 1'b1;
                    ram_wdata_nx = 9'h000;
                end
            end
            default:     state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= 9'h000;
        end else begin
            state     <= state_nx;
            ram_en    <= ram_en_nx;
            ram_we    <= ram_we_nx;
            ram_addr  <= ram_addr_nx;
            ram_wdata <= ram_wdata_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_pend <= 1'b0;
        end else if (clr_start) begin
            clr_pend <= 1'b0;
        end else if (clr) begin
            clr_pend <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_flag   <= 1'b0;
            brk_flag   <= 1'b0;
            pend_valid <= 1'b0;
            pending    <= 9'h000;
            count      <= '0;
            overflow   <= 1'b0;
        end else if (clr_start) begin
            ext_flag   <= 1'b0;
            brk_flag   <= 1'b0;
            pend_valid <= 1'b0;
            pending    <= 9'h000;
            count      <= '0;
            overflow   <= 1'b0;
        end else begin
            if (state == S_WRITE) begin
                count      <= count + 1'b1;
                pend_valid <= 1'b0;
            end
            if (code_valid) begin
                if (key_code == 8'hE0) begin
                    ext_flag <= 1'b1;
                end else if (key_code == 8'hF0) begin
                    brk_flag <= 1'b1;
                end else if (brk_flag) begin
                    ext_flag <= 1'b0;
                    brk_flag <= 1'b0;
                end else begin
                    ext_flag <= 1'b0;
                    if (pend_load) begin
                        pending    <= {ext_flag, key_code};
                        pend_valid <= 1'b1;
                    end else begin
                        overflow <= 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= 9'h000;
        end else if (state == S_READ_WAIT) begin
            rd_data_q <= ram_rdata;
        end
    end

endmodule

// File: tb/tb_kbd_bram_ctrl.sv
// Directed bench for kbd_bram_ctrl with a behavioural single-port BRAM model.

module tb_kbd_bram_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       code_valid = 1'b0;
    logic [7:0] key_code = 8'h00;
    logic       clr = 1'b0;
    logic       rd_req = 1'b0;
    logic [3:0] rd_addr = 4'h0;
    logic       ram_en, ram_we;
    logic [3:0] ram_addr;
    logic [8:0] ram_wdata;
    logic [8:0] ram_rdata;
    logic [8:0] rd_data;
    logic       rd_valid;
    logic [4:0] count;
    logic       full, busy, overflow;

    logic       fill_mem = 1'b0;
    logic [8:0] mem [0:15];
    int         n_writes = 0;
    int         n_tests = 0;
    int         n_fail = 0;

    kbd_bram_ctrl #(.ADDR_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .code_valid(code_valid), .key_code(key_code),
        .clr(clr), .rd_req(rd_req), .rd_addr(rd_addr), .ram_en(ram_en),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .rd_data(rd_data), .rd_valid(rd_valid),
        .count(count), .full(full), .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (fill_mem) begin
            for (int i = 0; i < 16; i++) mem[i] <= 9'h155;
        end else if (ram_en) begin
            if (ram_we) begin
                mem[ram_addr] <= ram_wdata;
                n_writes      <= n_writes + 1;
            end else begin
                ram_rdata <= mem[ram_addr];
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        code_valid = 1'b1;
        key_code   = b;
        tick();
        code_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        code_valid = 1'b0; clr = 1'b0; rd_req = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic do_read(input logic [3:0] a, output logic [8:0] d, output int lat);
        rd_req  = 1'b1;
        rd_addr = a;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (rd_valid) begin
                lat = k;
                break;
            end
        end
        rd_req = 1'b0;
        d = rd_data;
        tick();
    endtask

    task automatic test_reset();
        fill_mem = 1'b1;
        rst_n = 1'b0;
        tick();
        fill_mem = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({ram_en, ram_we, ram_addr, ram_wdata, rd_data, rd_valid, count, full, busy, overflow} !== 33'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got en=%b we=%b addr=%h wd=%h rd=%h rv=%b cnt=%0d full=%b busy=%b ovf=%b, required all zero",
                     ram_en, ram_we, ram_addr, ram_wdata, rd_data, rd_valid, count, full, busy, overflow);
        end
        do_reset();
        @(negedge clk);
        n_tests++;
        if ({ram_en, busy, count, overflow} !== 8'd0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got en=%b busy=%b cnt=%0d ovf=%b, required 0",
                     ram_en, busy, count, overflow);
        end
    endtask

    task automatic test_make_code();
        send_byte(8'h1C);
        @(negedge clk);
        n_tests++;
        if ({ram_en, ram_we, ram_addr, ram_wdata, busy} !== {1'b1, 1'b1, 4'h0, 9'h01C, 1'b1}) begin
            n_fail++;
            $display("FAIL make_write: got en=%b we=%b addr=%h wd=%h busy=%b, required 1 1 0 01c 1",
                     ram_en, ram_we, ram_addr, ram_wdata, busy);
        end
        tick();
        @(negedge clk);
        n_tests++;
        if ({ram_we, count} !== {1'b0, 5'd1}) begin
            n_fail++;
            $display("FAIL make_count: got we=%b cnt=%0d, required we=0 cnt=1", ram_we, count);
        end
    endtask

    task automatic test_break_ext();
        int w0;
        w0 = n_writes;
        send_byte(8'hF0);
        send_byte(8'h1C);
        tick();
        tick();
        n_tests++;
        if (n_writes - w0 !== 0 || count !== 5'd1) begin
            n_fail++;
            $display("FAIL break_no_write: got writes=%0d cnt=%0d, required 0 and 1", n_writes - w0, count);
        end
        send_byte(8'hE0);
        send_byte(8'h75);
        @(negedge clk);
        n_tests++;
        if ({ram_we, ram_addr, ram_wdata} !== {1'b1, 4'h1, 9'h175}) begin
            n_fail++;
            $display("FAIL ext_write: got we=%b addr=%h wd=%h, required 1 1 175", ram_we, ram_addr, ram_wdata);
        end
        tick();
    endtask

    task automatic test_ext_break();
        int w0;
        w0 = n_writes;
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        tick();
        tick();
        n_tests++;
        if (n_writes - w0 !== 0 || count !== 5'd2) begin
            n_fail++;
            $display("FAIL ext_break_no_write: got writes=%0d cnt=%0d, required 0 and 2", n_writes - w0, count);
        end
        send_byte(8'h1C);
        @(negedge clk);
        n_tests++;
        if ({ram_we, ram_addr, ram_wdata} !== {1'b1, 4'h2, 9'h01C}) begin
            n_fail++;
            $display("FAIL ext_cleared: got we=%b addr=%h wd=%h, required 1 2 01c", ram_we, ram_addr, ram_wdata);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int lat, pulses;
        logic [8:0] d;
        do_reset();
        send_byte(8'h1C);
        tick();
        send_byte(8'h32);
        tick();
        code_valid = 1'b1; key_code = 8'h21;
        rd_req = 1'b1; rd_addr = 4'h1;
        tick();
        code_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({ram_we, ram_addr, ram_wdata} !== {1'b1, 4'h2, 9'h021}) begin
            n_fail++;
            $display("FAIL contend_write_first: got we=%b addr=%h wd=%h, required 1 2 021", ram_we, ram_addr, ram_wdata);
        end
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (rd_valid) begin
                lat = k;
                break;
            end
        end
        rd_req = 1'b0;
        n_tests++;
        if (lat !== 3 || rd_data !== 9'h032) begin
            n_fail++;
            $display("FAIL contend_read: got lat=%0d data=%h, required lat=3 data=032", lat, rd_data);
        end
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (rd_valid) pulses++;
        end
        n_tests++;
        if (pulses !== 0 || rd_data !== 9'h032 || count !== 5'd3) begin
            n_fail++;
            $display("FAIL contend_after: got extra_pulses=%0d data=%h cnt=%0d, required 0 032 3", pulses, rd_data, count);
        end
        tick();
        do_read(4'h0, d, lat);
        n_tests++;
        if (lat !== 3 || d !== 9'h01C) begin
            n_fail++;
            $display("FAIL read_addr0: got lat=%0d data=%h, required lat=3 data=01c", lat, d);
        end
        do_read(4'h2, d, lat);
        n_tests++;
        if (lat !== 3 || d !== 9'h021) begin
            n_fail++;
            $display("FAIL read_addr2: got lat=%0d data=%h, required lat=3 data=021", lat, d);
        end
    endtask

    task automatic test_every_cycle_drop();
        do_reset();
        code_valid = 1'b1; key_code = 8'h1C;
        tick();
        key_code = 8'h2D;
        tick();
        code_valid = 1'b0;
        tick();
        @(negedge clk);
        n_tests++;
        if (count !== 5'd1 || overflow !== 1'b1 || mem[0] !== 9'h01C) begin
            n_fail++;
            $display("FAIL busy_drop: got cnt=%0d ovf=%b mem0=%h, required 1 1 01c", count, overflow, mem[0]);
        end
    endtask

    task automatic test_clr_latched();
        int seen;
        send_byte(8'h33);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || count !== 5'd2) begin
            n_fail++;
            $display("FAIL clr_latch_idle: got busy=%b cnt=%0d, required 0 2", busy, count);
        end
        tick();
        @(negedge clk);
        n_tests++;
        if ({busy, ram_we, ram_addr, count, overflow} !== {1'b1, 1'b1, 4'h0, 5'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL clr_latch_start: got busy=%b we=%b addr=%h cnt=%0d ovf=%b, required 1 1 0 0 0",
                     busy, ram_we, ram_addr, count, overflow);
        end
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!busy) begin
                seen = 1;
                break;
            end
        end
        n_tests++;
        if (seen !== 1) begin
            n_fail++;
            $display("FAIL clr_latch_end: got busy still high after 40 cycles, required idle");
        end
        tick();
    endtask

    task automatic test_fill_overflow();
        int w0;
        do_reset();
        w0 = n_writes;
        for (int i = 0; i < 17; i++) begin
            send_byte(8'(8'h10 + i));
            tick();
            tick();
            if (i == 15) begin
                n_tests++;
                if ({count, full, overflow} !== {5'd16, 1'b1, 1'b0}) begin
                    n_fail++;
                    $display("FAIL fill_16: got cnt=%0d full=%b ovf=%b, required 16 1 0", count, full, overflow);
                end
            end
        end
        n_tests++;
        if ({count, full, overflow} !== {5'd16, 1'b1, 1'b1} || n_writes - w0 !== 16) begin
            n_fail++;
            $display("FAIL fill_17: got cnt=%0d full=%b ovf=%b writes=%0d, required 16 1 1 16",
                     count, full, overflow, n_writes - w0);
        end
        n_tests++;
        if (mem[15] !== 9'h01F || mem[0] !== 9'h010) begin
            n_fail++;
            $display("FAIL fill_contents: got mem0=%h mem15=%h, required 010 01f", mem[0], mem[15]);
        end
    endtask

    task automatic test_clear();
        int busy_cycles, bad, lat;
        logic [8:0] ored, d;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        busy_cycles = 0;
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (busy) begin
                if (!ram_we || ram_addr !== 4'(busy_cycles) || ram_wdata !== 9'h000) bad++;
                busy_cycles++;
            end else begin
                break;
            end
        end
        n_tests++;
        if (busy_cycles !== 16 || bad !== 0) begin
            n_fail++;
            $display("FAIL clear_sweep: got busy_cycles=%0d bad_writes=%0d, required 16 0", busy_cycles, bad);
        end
        ored = 9'h000;
        for (int i = 0; i < 16; i++) ored = ored | mem[i];
        n_tests++;
        if ({count, full, overflow} !== {5'd0, 1'b0, 1'b0} || ored !== 9'h000) begin
            n_fail++;
            $display("FAIL clear_state: got cnt=%0d full=%b ovf=%b mem_or=%h, required 0 0 0 000",
                     count, full, overflow, ored);
        end
        tick();
        do_read(4'h5, d, lat);
        n_tests++;
        if (lat !== 3 || d !== 9'h000) begin
            n_fail++;
            $display("FAIL clear_read5: got lat=%0d data=%h, required lat=3 data=000", lat, d);
        end
    endtask

    initial begin
        test_reset();
        test_make_code();
        test_break_ext();
        test_ext_break();
        test_back_to_back();
        test_every_cycle_drop();
        test_clr_latched();
        test_fill_overflow();
        test_clear();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
